// File: rtl/controller_led_blinker.sv
// controller_led_blinker
// Turns the LED-period word from the PIO into a blinking LED drive signal.
// One blink cycle lasts active_period clocks: on for floor(P/2) clocks, then
// off for the rest. A new period is picked up only at a cycle boundary, so
// software writes to the PIO never shorten or stretch the cycle in progress.
// Completed cycles raise cycle_done and advance a wrapping cycle_count.
module controller_led_blinker #(
  parameter int PERIOD_WIDTH = 24,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period_in,
  output logic                    led_out,
  output logic                    busy,
  output logic [PERIOD_WIDTH-1:0] active_period,
  output logic                    cycle_done,
  output logic [CNT_WIDTH-1:0]    cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] phase_cnt;
  logic [PERIOD_WIDTH-1:0] on_len;
  logic [PERIOD_WIDTH-1:0] off_len;
  logic                    period_ok;
  logic                    valid;
  logic                    on_last;
  logic                    off_last;

  // Periods of 0 and 1 cannot produce both an on and an off phase, so they
  // are treated as a stop request.
  function automatic logic period_usable(input logic [PERIOD_WIDTH-1:0] p);
    return (p >= PERIOD_WIDTH'(2));
  endfunction

  // on_len + off_len always equals active_period, so neither can overflow.
  assign on_len    = active_period >> 1;
  assign off_len   = active_period - on_len;
  assign period_ok = period_usable(period_in);
  assign valid     = enable && period_ok;
  assign on_last   = (phase_cnt == (on_len - PERIOD_WIDTH'(1)));
  assign off_last  = (phase_cnt == (off_len - PERIOD_WIDTH'(1)));

  // Blink FSM with registered outputs; period shadow loads only in IDLE or on
  // the last OFF clock, and dropping enable aborts without counting a cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      phase_cnt     <= '0;
      active_period <= '0;
      led_out       <= 1'b0;
      busy          <= 1'b0;
      cycle_done    <= 1'b0;
      cycle_count   <= '0;
    end else begin
      cycle_done <= 1'b0;
      case (state)
        IDLE: begin
          phase_cnt <= '0;
          if (valid) begin
            active_period <= period_in;
            state         <= ON;
            led_out       <= 1'b1;
            busy          <= 1'b1;
          end else begin
            led_out <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ON: begin
          if (!enable) begin
            state     <= IDLE;
            phase_cnt <= '0;
            led_out   <= 1'b0;
            busy      <= 1'b0;
          end else if (on_last) begin
            state     <= OFF;
            phase_cnt <= '0;
            led_out   <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + PERIOD_WIDTH'(1);
          end
        end
        OFF: begin
          if (!enable) begin
            state     <= IDLE;
            phase_cnt <= '0;
            led_out   <= 1'b0;
            busy      <= 1'b0;
          end else if (off_last) begin
            cycle_done  <= 1'b1;
            cycle_count <= cycle_count + CNT_WIDTH'(1);
            phase_cnt   <= '0;
            if (period_ok) begin
              active_period <= period_in;
              state         <= ON;
              led_out       <= 1'b1;
            end else begin
              state   <= IDLE;
              led_out <= 1'b0;
              busy    <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_cnt + PERIOD_WIDTH'(1);
          end
        end
        default: begin
          state     <= IDLE;
          phase_cnt <= '0;
          led_out   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
